// File: rtl/contador_ctrl_if.sv
// Readout and lane-input bundle for contador_ctrl.
// The slave side is the counter block; the master side drives lanes and consumes words.
interface contador_ctrl_if #(
    parameter int LANES = 4,
    parameter int DW    = 12,
    parameter int CW    = 16
);
    localparam int LW = $clog2(LANES);

    logic [LANES*DW-1:0] data_in;
    logic                enable;
    logic                clr_on_read;
    logic                rd_req;
    logic                out_ready;
    logic                out_valid;
    logic [LW-1:0]       out_lane;
    logic [CW-1:0]       out_count;
    logic                out_ovf;
    logic                rd_busy;
    logic                rd_done;

    modport slave (
        input  data_in, enable, clr_on_read, rd_req, out_ready,
        output out_valid, out_lane, out_count, out_ovf, rd_busy, rd_done
    );

    modport master (
        output data_in, enable, clr_on_read, rd_req, out_ready,
        input  out_valid, out_lane, out_count, out_ovf, rd_busy, rd_done
    );
endinterface

// File: rtl/contador_ctrl.sv
// Per-lane change counter with saturating counts and a snapshot readout.
// Live counters keep running during readout; the readout streams frozen
// shadow copies one lane per accepted word.
module contador_ctrl #(
    parameter int LANES = 4,
    parameter int DW    = 12,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             reset,
    contador_ctrl_if.slave   bus
);
    localparam int LW = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, SNAP, SEND, DONE} state_t;

    state_t            state_reg, state_next;
    logic [LW-1:0]     ptr_reg, ptr_next;
    logic              snap;
    logic              sending;

    // Shadow values gathered from every lane so the readout mux can index them.
    logic [LANES-1:0][CW-1:0] shadow_count;
    logic [LANES-1:0]         shadow_ovf;

    assign snap    = (state_reg == SNAP);
    assign sending = (state_reg == SEND);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DW-1:0] detector_reg;
            logic [CW-1:0] count_reg;
            logic          ovf_reg;
            logic [CW-1:0] shadow_count_reg;
            logic          shadow_ovf_reg;
            logic [DW-1:0] lane_data;
            logic          counted;

            assign lane_data = bus.data_in[gi*DW +: DW];
            assign counted   = bus.enable && (lane_data != detector_reg);

            // Lane state: detector follows the input every cycle; the counter
            // saturates at all-ones and flags overflow; snapshot captures the
            // pre-increment value and optionally restarts the live count.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    detector_reg     <= '0;
                    count_reg        <= '0;
                    ovf_reg          <= 1'b0;
                    shadow_count_reg <= '0;
                    shadow_ovf_reg   <= 1'b0;
                end else begin
                    detector_reg <= lane_data;
                    if (snap) begin
                        shadow_count_reg <= count_reg;
                        shadow_ovf_reg   <= ovf_reg;
                    end
                    if (snap && bus.clr_on_read) begin
                        count_reg <= counted ? CW'(1) : '0;
                        ovf_reg   <= 1'b0;
                    end else if (counted) begin
                        if (&count_reg) begin
                            ovf_reg <= 1'b1;
                        end else begin
                            count_reg <= count_reg + CW'(1);
                        end
                    end
                end
            end

            assign shadow_count[gi] = shadow_count_reg;
            assign shadow_ovf[gi]   = shadow_ovf_reg;
        end
    endgenerate

    // Readout FSM state and lane pointer registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    // Readout sequencing: request -> one snapshot cycle -> one word per lane -> done pulse.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (bus.rd_req) begin
                    state_next = SNAP;
                end
            end
            SNAP: begin
                ptr_next   = '0;
                state_next = SEND;
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (ptr_reg == LW'(LANES-1)) begin
                        state_next = DONE;
                    end else begin
                        ptr_next = ptr_reg + LW'(1);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Word outputs are forced to zero outside SEND; inside SEND they only
    // depend on the pointer, so they stay put while the consumer stalls.
    assign bus.out_valid = sending;
    assign bus.out_lane  = sending ? ptr_reg : '0;
    assign bus.out_count = sending ? shadow_count[ptr_reg] : '0;
    assign bus.out_ovf   = sending ? shadow_ovf[ptr_reg] : 1'b0;
    assign bus.rd_busy   = (state_reg != IDLE);
    assign bus.rd_done   = (state_reg == DONE);

endmodule

// File: tb/tb_contador_ctrl.sv
// Randomized bench for contador_ctrl against a plain per-lane counting model.
module tb_contador_ctrl;
    localparam int LANES = 4;
    localparam int DW    = 12;
    localparam int CW    = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    contador_ctrl_if #(.LANES(LANES), .DW(DW), .CW(CW)) bus ();

    contador_ctrl #(.LANES(LANES), .DW(DW), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: last seen lane values, live counts, flags, snapshot.
    int live   [LANES];
    bit movf   [LANES];
    int prev   [LANES];
    int shadow [LANES];
    bit sovf   [LANES];
    bit snap_now = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply the counting rules to the inputs present at the coming edge.
    task automatic model_edge();
        int  lane;
        bit  cnt;
        for (int i = 0; i < LANES; i++) begin
            if (!reset) begin
                live[i] = 0; movf[i] = 0; prev[i] = 0; shadow[i] = 0; sovf[i] = 0;
            end else begin
                lane = int'(bus.data_in[i*DW +: DW]);
                cnt  = (lane != prev[i]) && bus.enable;
                if (snap_now) begin
                    shadow[i] = live[i];
                    sovf[i]   = movf[i];
                end
                if (snap_now && bus.clr_on_read) begin
                    live[i] = cnt ? 1 : 0;
                    movf[i] = 0;
                end else if (cnt) begin
                    if (live[i] == 65535) movf[i] = 1;
                    else live[i] = live[i] + 1;
                end
                prev[i] = lane;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data(input bit with_req);
        for (int i = 0; i < LANES; i++) begin
            if ($urandom_range(1, 0) == 1) bus.data_in[i*DW +: DW] = DW'($urandom);
        end
        bus.enable      = ($urandom_range(3, 0) != 0);
        bus.clr_on_read = 1'($urandom_range(1, 0));
        if (with_req) bus.rd_req = 1'($urandom_range(1, 0));
    endtask

    // Full readout: request, snapshot, four words (optional stall on one lane), done.
    task automatic do_readout(input int stall_lane, input int stall_n, input bit rnd, input bit chg0_at_snap);
        if (rnd) rand_data(1'b0);
        bus.rd_req    = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        check_eq("snap_valid", bus.out_valid, 0);
        check_eq("snap_busy", bus.rd_busy, 1);
        if (chg0_at_snap) bus.data_in[DW-1:0] = ~bus.data_in[DW-1:0];
        else if (rnd) rand_data(1'b1);
        snap_now = 1'b1;
        tick();
        snap_now = 1'b0;
        for (int ln = 0; ln < LANES; ln++) begin
            if (ln == stall_lane) begin
                bus.out_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    check_eq("stall_valid", bus.out_valid, 1);
                    check_eq("stall_lane", bus.out_lane, ln);
                    check_eq("stall_count", bus.out_count, shadow[ln]);
                    if (rnd) rand_data(1'b1);
                    tick();
                end
                bus.out_ready = 1'b1;
            end
            check_eq("word_valid", bus.out_valid, 1);
            check_eq("word_lane", bus.out_lane, ln);
            check_eq("word_count", bus.out_count, shadow[ln]);
            check_eq("word_ovf", bus.out_ovf, sovf[ln]);
            check_eq("word_done_low", bus.rd_done, 0);
            $display("[TB] word lane=%0d count=%0d ovf=%0d", bus.out_lane, bus.out_count, bus.out_ovf);
            if (rnd) rand_data(1'b1);
            tick();
        end
        check_eq("done_pulse", bus.rd_done, 1);
        check_eq("done_valid", bus.out_valid, 0);
        check_eq("done_busy", bus.rd_busy, 1);
        if (rnd) rand_data(1'b1);
        tick();
        check_eq("idle_done", bus.rd_done, 0);
        check_eq("idle_busy", bus.rd_busy, 0);
        bus.rd_req = 1'b0;
        tick();
        check_eq("no_queue_busy", bus.rd_busy, 0);
    endtask

    initial begin
        bus.data_in     = '0;
        bus.enable      = 1'b0;
        bus.clr_on_read = 1'b0;
        bus.rd_req      = 1'b0;
        bus.out_ready   = 1'b0;

        // Reset state
        reset = 1'b0;
        tick();
        tick();
        check_eq("rst_valid", bus.out_valid, 0);
        check_eq("rst_busy", bus.rd_busy, 0);
        check_eq("rst_done", bus.rd_done, 0);
        check_eq("rst_count", bus.out_count, 0);
        check_eq("rst_lane", bus.out_lane, 0);

        // Lane0 toggles ten times with enable, others static
        reset      = 1'b1;
        bus.enable = 1'b1;
        for (int n = 0; n < 10; n++) begin
            bus.data_in[DW-1:0] = (n % 2 == 0) ? 12'hABC : 12'h000;
            tick();
        end
        check_eq("model_lane0_ten", shadow[0] + live[0], 10);
        do_readout(-1, 0, 1'b0, 1'b0);

        // Consumer stall during lane1
        bus.data_in[DW +: DW] = 12'h123;
        tick();
        do_readout(1, 3, 1'b0, 1'b0);

        // Clear-on-read with a lane0 change in the snapshot cycle
        bus.clr_on_read = 1'b1;
        do_readout(-1, 0, 1'b0, 1'b1);
        bus.clr_on_read = 1'b0;
        check_eq("model_live_after_clr", live[0], 1);
        do_readout(-1, 0, 1'b0, 1'b1);

        // Random traffic with interleaved readouts
        for (int r = 0; r < 20; r++) begin
            int gap;
            gap = $urandom_range(15, 1);
            for (int c = 0; c < gap; c++) begin
                rand_data(1'b0);
                tick();
            end
            do_readout($urandom_range(4, 0), $urandom_range(4, 1), 1'b1, 1'b0);
        end

        // Saturation on lane2
        reset = 1'b0;
        bus.data_in = '0;
        tick();
        reset           = 1'b1;
        bus.enable      = 1'b1;
        bus.clr_on_read = 1'b0;
        for (int n = 0; n < 65536; n++) begin
            bus.data_in[2*DW +: DW] = (n % 2 == 0) ? 12'h555 : 12'h000;
            tick();
        end
        do_readout(-1, 0, 1'b0, 1'b0);
        check_eq("sat_count_model", shadow[2], 65535);

        // Reset mid-SEND while lane2 is on the bus
        bus.rd_req    = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        snap_now   = 1'b1;
        tick();
        snap_now = 1'b0;
        tick();
        tick();
        check_eq("mid_lane2", bus.out_lane, 2);
        check_eq("mid_count2", bus.out_count, shadow[2]);
        check_eq("mid_ovf2", bus.out_ovf, 1);
        reset       = 1'b0;
        bus.data_in = '0;
        tick();
        check_eq("midrst_valid", bus.out_valid, 0);
        check_eq("midrst_busy", bus.rd_busy, 0);
        check_eq("midrst_count", bus.out_count, 0);
        reset = 1'b1;
        tick();
        check_eq("post_rst_busy", bus.rd_busy, 0);
        do_readout(-1, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
